// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the two-requester single-port RAM arbiter.
package sp_ram_pkg;

    localparam int NUM_REQ  = 2;
    localparam int REQ_CORE = 0;
    localparam int REQ_ACC  = 1;
    localparam int BE_WIDTH = 4;

    // One entry per granted access, retired on the following cycle.
    typedef struct packed {
        logic valid;
        logic owner;
        logic is_read;
    } resp_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sp_ram_arb_rr.sv
// Grant logic for two requesters; round-robin when SP_RAM_ARB_RR_EN is defined,
// otherwise fixed priority with the core (M0) winning every conflict.
module sp_ram_arb_rr
    import sp_ram_pkg::*;
(
`ifdef SP_RAM_ARB_RR_EN
    input  logic               clk_i,
`endif
    input  logic               rstn_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

`ifdef SP_RAM_ARB_RR_EN
    // Set means the accelerator was granted last, so the core is preferred next.
    logic last_acc_p1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_acc_p1 <= 1'b1;
        end else if (|gnt_o) begin
            last_acc_p1 <= gnt_o[REQ_ACC];
        end
    end

    always_comb begin
        gnt_o = '0;
        if (rstn_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_acc_p1 ? 2'b01 : 2'b10;
                default: gnt_o = '0;
            endcase
        end
    end
`else
    always_comb begin
        gnt_o = '0;
        if (rstn_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = 2'b01;
                default: gnt_o = '0;
            endcase
        end
    end
`endif

endmodule

// File: rtl/sp_ram_arbiter.sv
// Arbitrates a core and an accelerator onto one single-port RAM bank with one-cycle
// responses. Build with SP_RAM_ARB_RR_EN for round-robin, otherwise fixed priority.
module sp_ram_arbiter
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [2*BE_WIDTH-1:0]     be_i,
    input  logic [2*ADDR_WIDTH-1:0]   addr_i,
    input  logic [2*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      en_o,
    output logic                      we_o,
    output logic [BE_WIDTH-1:0]       be_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    input  logic [DATA_WIDTH-1:0]     rdata_i
);

    logic [NUM_REQ-1:0]    gnt_p0;
    resp_t                 resp_p0;
    resp_t                 resp_p1;
    logic [DATA_WIDTH-1:0] rdata_hold_p1;

    sp_ram_arb_rr u_arb (
`ifdef SP_RAM_ARB_RR_EN
        .clk_i  (clk_i),
`endif
        .rstn_i (rstn_i),
        .req_i  (req_i),
        .gnt_o  (gnt_p0)
    );

    assign gnt_o = gnt_p0;

    // Stage p0: route the granted requester onto the bank port.
    always_comb begin
        en_o    = 1'b0;
        we_o    = 1'b0;
        be_o    = '0;
        addr_o  = '0;
        wdata_o = '0;
        if (gnt_p0[REQ_CORE]) begin
            en_o    = 1'b1;
            we_o    = we_i[REQ_CORE];
            be_o    = be_i[BE_WIDTH-1:0];
            addr_o  = addr_i[ADDR_WIDTH-1:0];
            wdata_o = wdata_i[DATA_WIDTH-1:0];
        end else if (gnt_p0[REQ_ACC]) begin
            en_o    = 1'b1;
            we_o    = we_i[REQ_ACC];
            be_o    = be_i[2*BE_WIDTH-1:BE_WIDTH];
            addr_o  = addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
            wdata_o = wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    always_comb begin
        resp_p0.valid   = en_o;
        resp_p0.owner   = gnt_p0[REQ_ACC];
        resp_p0.is_read = en_o & ~we_o;
    end

    // Stage p1: bank data arrives; track the response and hold the last read word.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_p1       <= '0;
            rdata_hold_p1 <= '0;
        end else begin
            resp_p1 <= resp_p0;
            if (resp_p1.valid && resp_p1.is_read) begin
                rdata_hold_p1 <= rdata_i;
            end
        end
    end

    assign rvalid_o = resp_p1.valid ? owner_onehot(resp_p1.owner) : '0;
    assign rdata_o  = (resp_p1.valid && resp_p1.is_read) ? rdata_i : rdata_hold_p1;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration, memory contents and read hold.
module tb_sp_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
`ifdef SP_RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [1:0]      req_i, we_i;
    logic [7:0]      be_i;
    logic [2*AW-1:0] addr_i;
    logic [2*DW-1:0] wdata_i;
    logic [1:0]      gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            en_o, we_o;
    logic [3:0]      be_o;
    logic [AW-1:0]   addr_o;
    logic [DW-1:0]   wdata_o;
    logic [DW-1:0]   rdata_i;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .en_o(en_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank emulation: synchronous word-addressed RAM with byte enables.
    logic [DW-1:0] bank_mem [0:15];
    always @(posedge clk) begin
        if (en_o) begin
            if (we_o) begin
                for (int b = 0; b < 4; b++)
                    if (be_o[b]) bank_mem[addr_o[5:2]][8*b +: 8] <= wdata_o[8*b +: 8];
            end else begin
                rdata_i <= bank_mem[addr_o[5:2]];
            end
        end
    end

    typedef struct {
        bit        act;
        bit        we;
        bit [3:0]  be;
        bit [15:0] addr;
        bit [31:0] wdata;
    } txn_t;

    typedef struct {
        int        cyc;
        bit        owner;
        bit [31:0] data;
    } exp_t;

    txn_t      pend [2];
    exp_t      sb [$];
    bit [31:0] ref_mem [0:15];
    bit [31:0] last_rd;
    bit        last_win;
    int        errors = 0;
    int        checks = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic issue(int m, bit we, bit [3:0] be, bit [15:0] addr, bit [31:0] wdata);
        pend[m].act   = 1'b1;
        pend[m].we    = we;
        pend[m].be    = be;
        pend[m].addr  = addr;
        pend[m].wdata = wdata;
    endtask

    task automatic apply_inputs();
        req_i   = {pend[1].act, pend[0].act};
        we_i    = {pend[1].we, pend[0].we};
        be_i    = {pend[1].be, pend[0].be};
        addr_i  = {pend[1].addr, pend[0].addr};
        wdata_i = {pend[1].wdata, pend[0].wdata};
    endtask

    function automatic void model_reset();
        last_win = 1'b1;
        last_rd  = '0;
        sb.delete();
    endfunction

    // One clock: present pending requests, predict the grant and bank access, queue the response.
    task automatic step();
        bit        any;
        bit        w;
        bit [31:0] d;
        bit [53:0] exp_port;
        apply_inputs();
        @(negedge clk);
        any = pend[0].act || pend[1].act;
        if (pend[0].act && pend[1].act) w = RR ? !last_win : 1'b0;
        else                            w = pend[1].act;
        chk("gnt", gnt_o, any ? (w ? 2'b10 : 2'b01) : 2'b00);
        exp_port = '0;
        if (any) begin
            exp_port = {1'b1, pend[w].we, pend[w].be, pend[w].addr, pend[w].wdata};
            if (!pend[w].we) begin
                d       = ref_mem[pend[w].addr[5:2]];
                last_rd = d;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (pend[w].be[b]) ref_mem[pend[w].addr[5:2]][8*b +: 8] = pend[w].wdata[8*b +: 8];
                d = last_rd;
            end
            sb.push_back('{cyc: cyc, owner: w, data: d});
            last_win    = w;
            pend[w].act = 1'b0;
        end
        chk("bank_port", {en_o, we_o, be_o, addr_o, wdata_o}, exp_port);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented response must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn_i === 1'b1) begin
                if (rvalid_o != 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rvalid", rvalid_o, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        chk("rvalid", rvalid_o, e.owner ? 2'b10 : 2'b01);
                        chk("rdata", rdata_o, e.data);
                        chk("resp_latency", cyc - e.cyc, 1);
                    end
                end else if (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
                    e = sb.pop_front();
                    chk("missing_rvalid", 2'b00, e.owner ? 2'b10 : 2'b01);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank_mem[i] = 32'hA5000000 + 32'(i * 32'h00010101);
            ref_mem[i]  = 32'hA5000000 + 32'(i * 32'h00010101);
        end
        bank_mem[4] = 32'hDEADBEEF;
        ref_mem[4]  = 32'hDEADBEEF;
        pend[0] = '{default: 0};
        pend[1] = '{default: 0};
        model_reset();
        rstn_i = 1'b0;
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid", rvalid_o, 2'b00);
        chk("reset_rdata", rdata_o, '0);
        chk("reset_gnt", gnt_o, 2'b00);
        rstn_i = 1'b1;
        step();

        // Core read of 0x0010 alone, then accelerator partial write to 0x0020.
        issue(0, 1'b0, 4'hF, 16'h0010, 32'h0);
        step();
        issue(1, 1'b1, 4'b0011, 16'h0020, 32'h12345678);
        step();
        step();

        // Back-to-back reads from different requesters.
        issue(0, 1'b0, 4'hF, 16'h0000, 32'h0);
        step();
        issue(1, 1'b0, 4'hF, 16'h0004, 32'h0);
        step();
        step();

        // Both requesters continuously active for four cycles.
        for (int k = 0; k < 4; k++) begin
            if (!pend[0].act) issue(0, 1'b0, 4'hF, 16'(8 + 4*k), 32'h0);
            if (!pend[1].act) issue(1, 1'b0, 4'hF, 16'(12 + 4*k), 32'h0);
            step();
        end
        while (pend[0].act || pend[1].act) step();
        step();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m].act && $urandom_range(0, 9) < 6)
                    issue(m, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                          16'($urandom_range(0, 15) * 4), $urandom);
            step();
        end
        while (pend[0].act || pend[1].act) step();
        step();

        // Reset in the cycle after a grant: response must vanish, hold and pointer clear.
        issue(1, 1'b0, 4'hF, 16'h0008, 32'h0);
        step();
        issue(1, 1'b0, 4'hF, 16'h000C, 32'h0);
        step();
        rstn_i = 1'b0;
        model_reset();
        issue(0, 1'b0, 4'hF, 16'h0004, 32'h0);
        apply_inputs();
        #1;
        chk("midreset_rvalid", rvalid_o, 2'b00);
        chk("midreset_rdata", rdata_o, '0);
        chk("midreset_gnt", gnt_o, 2'b00);
        chk("midreset_en", en_o, 1'b0);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        #2;
        chk("postreset_rvalid", rvalid_o, 2'b00);
        chk("postreset_rdata", rdata_o, '0);
        step();
        while (pend[0].act || pend[1].act) step();
        repeat (3) step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
